// File: rtl/fft_twiddle_sequencer.sv
// fft_twiddle_sequencer
//
// Initiator side of the twiddle lookup for an N-point radix-2 DIT FFT. The block walks
// every stage s (outer loop) and butterfly j (inner loop). For each pair it drives the
// twiddle ROM address k = (j & (2^s - 1)) << (LOG2N-1-s). The ROM is built with
// rom_len = N/2 and stage_no = 1. The block registers the returned W_re/W_im and presents
// them on a valid/ready stream, tagged with the stage and butterfly index.
//
// The pipeline has two registered stages:
//   A: rom_addr plus the s/j/last tags and an internal a_valid.
//   B: the tw_* outputs. B captures rom_re/rom_im and the A tags.
//
// Optional build macro TWID_CONJ_EN: adds the inverse input. inverse is sampled when a
// start is accepted. While it is set, tw_im is the saturated negation of rom_im.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     one-cycle pulse; begins a sweep when idle
//   inverse   (TWID_CONJ_EN only) conjugate twiddles for this sweep
//   rom_addr  twiddle ROM address (zero-extended k)
//   rom_re    W_re from ROM, combinational on rom_addr
//   rom_im    W_im from ROM, combinational on rom_addr
//   tw_valid  output word valid
//   tw_ready  downstream accepts word
//   tw_re     twiddle real part
//   tw_im     twiddle imaginary part
//   tw_stage  stage index of word
//   tw_bfly   butterfly index of word
//   tw_last   final word of the sweep
//   busy      high from accepted start until final word accepted
//   done      one-cycle pulse after final word accepted
module fft_twiddle_sequencer #(
    parameter int unsigned N     = 1024,
    parameter int unsigned LOG2N = 10,
    parameter int unsigned AW    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
`ifdef TWID_CONJ_EN
    input  logic                inverse,
`endif
    output logic [AW-1:0]       rom_addr,
    input  logic signed [15:0]  rom_re,
    input  logic signed [15:0]  rom_im,
    output logic                tw_valid,
    input  logic                tw_ready,
    output logic signed [15:0]  tw_re,
    output logic signed [15:0]  tw_im,
    output logic [3:0]          tw_stage,
    output logic [LOG2N-2:0]    tw_bfly,
    output logic                tw_last,
    output logic                busy,
    output logic                done
);

    localparam int unsigned JW = LOG2N - 1;

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e          state_q, state_d;

    // Next (s, j) to issue while running.
    logic [3:0]      s_q;
    logic [JW-1:0]   j_q;

    // Stage A.
    logic            a_valid_q;
    logic [3:0]      a_s_q;
    logic [JW-1:0]   a_j_q;
    logic            a_last_q;

    logic            b_load;
    logic            a_adv;
    logic            issue;
    logic            issue_last;
    logic            hs_last;
    logic [3:0]      issue_s;
    logic [JW-1:0]   issue_j;
    logic [JW-1:0]   mask;
    logic [JW-1:0]   k;
    logic [3:0]      shamt;
    logic signed [15:0] im_next;

`ifdef TWID_CONJ_EN
    logic            inverse_q;
`endif

    assign b_load  = a_valid_q && (!tw_valid || tw_ready);
    assign a_adv   = !a_valid_q || b_load;
    assign hs_last = tw_valid && tw_ready && tw_last;

    // From idle the first word goes straight into A, so rom_addr is valid right after the
    // start edge.
    always_comb begin
        issue_s = s_q;
        issue_j = j_q;
        if (state_q == StIdle) begin
            issue_s = '0;
            issue_j = '0;
        end
    end

    assign issue      = ((state_q == StIdle) && start) || ((state_q == StRun) && a_adv);
    assign issue_last = (issue_s == 4'(LOG2N - 1)) && (issue_j == JW'(N / 2 - 1));

    // k = (j mod 2^s) * 2^(LOG2N-1-s)
    always_comb begin
        mask  = ~({JW{1'b1}} << issue_s);
        shamt = 4'(LOG2N - 1) - issue_s;
        k     = (issue_j & mask) << shamt;
    end

    always_comb begin
        im_next = rom_im;
`ifdef TWID_CONJ_EN
        if (inverse_q) begin
            // -(-32768) does not fit in 16 bits, so it saturates to +32767.
            im_next = (rom_im == 16'sh8000) ? 16'sh7fff : -rom_im;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (issue && issue_last) state_d = StFlush;
            StFlush: if (hs_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy = (state_q != StIdle);
    end

    // Counters and stage A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= '0;
            j_q       <= '0;
            a_valid_q <= 1'b0;
            a_s_q     <= '0;
            a_j_q     <= '0;
            a_last_q  <= 1'b0;
            rom_addr  <= '0;
        end else if (issue) begin
            if (issue_j == JW'(N / 2 - 1)) begin
                j_q <= '0;
                if (!issue_last) s_q <= issue_s + 4'd1;
            end else begin
                j_q <= issue_j + JW'(1);
                s_q <= issue_s;
            end
            a_valid_q <= 1'b1;
            a_s_q     <= issue_s;
            a_j_q     <= issue_j;
            a_last_q  <= issue_last;
            rom_addr  <= AW'(k);
        end else if (b_load) begin
            // Only reached while flushing: the last word has moved to B.
            a_valid_q <= 1'b0;
        end
    end

    // Stage B and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tw_valid <= 1'b0;
            tw_re    <= '0;
            tw_im    <= '0;
            tw_stage <= '0;
            tw_bfly  <= '0;
            tw_last  <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (b_load) begin
                tw_valid <= 1'b1;
                tw_re    <= rom_re;
                tw_im    <= im_next;
                tw_stage <= a_s_q;
                tw_bfly  <= a_j_q;
                tw_last  <= a_last_q;
            end else if (tw_ready) begin
                tw_valid <= 1'b0;
            end
            done <= (state_q == StFlush) && hs_last;
        end
    end

`ifdef TWID_CONJ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inverse_q <= 1'b0;
        end else if ((state_q == StIdle) && start) begin
            inverse_q <= inverse;
        end
    end
`endif

endmodule

// File: tb/tb_fft_twiddle_sequencer.sv
module tb_fft_twiddle_sequencer;

    localparam int N     = 8;
    localparam int LOG2N = 3;
    localparam int AW    = 16;
    localparam int TOTAL = LOG2N * N / 2;
    localparam int SW    = AW + 16 + 16 + 4 + (LOG2N - 1) + 1;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic                     inv = 1'b0;
    logic [AW-1:0]            rom_addr;
    logic signed [15:0]       rom_re;
    logic signed [15:0]       rom_im;
    logic                     tw_valid;
    logic                     tw_ready = 1'b1;
    logic signed [15:0]       tw_re;
    logic signed [15:0]       tw_im;
    logic [3:0]               tw_stage;
    logic [LOG2N-2:0]         tw_bfly;
    logic                     tw_last;
    logic                     busy;
    logic                     done;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_addr [TOTAL];
    int exp_s    [TOTAL];
    int exp_j    [TOTAL];

    always #5 clk = ~clk;

    fft_twiddle_sequencer #(.N(N), .LOG2N(LOG2N), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
`ifdef TWID_CONJ_EN
        .inverse  (inv),
`endif
        .rom_addr (rom_addr),
        .rom_re   (rom_re),
        .rom_im   (rom_im),
        .tw_valid (tw_valid),
        .tw_ready (tw_ready),
        .tw_re    (tw_re),
        .tw_im    (tw_im),
        .tw_stage (tw_stage),
        .tw_bfly  (tw_bfly),
        .tw_last  (tw_last),
        .busy     (busy),
        .done     (done)
    );

    // ROM model: real part encodes the address, imaginary part has a -32768 entry at 2.
    function automatic logic signed [15:0] rom_re_f(input int a);
        return 16'(a * 1111 + 3);
    endfunction

    function automatic logic signed [15:0] rom_im_f(input int a);
        return (a == 2) ? 16'sh8000 : 16'sh1234;
    endfunction

    always_comb begin
        rom_re = rom_re_f(int'(rom_addr));
        rom_im = rom_im_f(int'(rom_addr));
    end

    // Reference sweep order and addresses from plain arithmetic.
    initial begin
        int idx;
        idx = 0;
        for (int s = 0; s < LOG2N; s++) begin
            for (int j = 0; j < N / 2; j++) begin
                exp_s[idx]    = s;
                exp_j[idx]    = j;
                exp_addr[idx] = (j % (1 << s)) * (1 << (LOG2N - 1 - s));
                idx++;
            end
        end
    end

    task automatic sweep(input int stall_word, input int stall_len, input bit rnd_ready,
                         input int abort_after, input int extra_start, input bit inv_sel,
                         input bit chk_timing);
        int idx = 0;
        int c = 0;
        int stalled = 0;
        int done_cnt = 0;
        int first = -1;
        int last_hs = -10;
        bit prev_stall = 1'b0;
        bit aborted = 1'b0;
        logic [SW-1:0] snap = '0;
        logic [SW-1:0] cur;
        logic signed [15:0] e_re;
        logic signed [15:0] e_im;

        @(negedge clk);
        inv      = inv_sel;
        start    = 1'b1;
        tw_ready = 1'b1;
        while (c < 200) begin
            @(negedge clk);
            c++;
            start = (c == extra_start);
            if (idx == stall_word && stalled < stall_len) begin
                tw_ready = 1'b0;
                stalled++;
            end else if (rnd_ready) begin
                tw_ready = ($urandom_range(0, 3) != 0);
            end else begin
                tw_ready = 1'b1;
            end

            if (abort_after >= 0 && idx == abort_after) begin
                rst_n = 1'b0;
                #1;
                n_tests++;
                if ({rom_addr, tw_valid, tw_re, tw_im, tw_stage, tw_bfly, tw_last, busy, done}
                    !== '0) begin
                    n_fail++;
                    $display("FAIL midreset_clear: addr=%0d valid=%0b re=%0d im=%0d busy=%0b, required all 0",
                             rom_addr, tw_valid, tw_re, tw_im, busy);
                end
                aborted = 1'b1;
                break;
            end

            #1;
            cur = {rom_addr, tw_re, tw_im, tw_stage, tw_bfly, tw_last};

            if (chk_timing && c <= TOTAL) begin
                n_tests++;
                if (rom_addr !== AW'(exp_addr[c-1])) begin
                    n_fail++;
                    $display("FAIL rom_addr_seq[%0d]: got %0d, required %0d", c - 1, rom_addr,
                             exp_addr[c-1]);
                end
            end

            if (chk_timing && first < 0 && tw_valid) begin
                first = c;
                n_tests++;
                if (c != 2) begin
                    n_fail++;
                    $display("FAIL first_valid_latency: got %0d cycles, required 2", c);
                end
            end

            if (prev_stall) begin
                n_tests++;
                if (cur !== snap || tw_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_hold: got %h valid=%0b, required %h valid=1", cur,
                             tw_valid, snap);
                end
            end

            if (done) begin
                done_cnt++;
                n_tests++;
                if (c != last_hs + 1 || idx != TOTAL || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_pulse: at cycle %0d words=%0d busy=%0b, required cycle %0d words=%0d busy=0",
                             c, idx, busy, last_hs + 1, TOTAL);
                end
            end

            if (tw_valid && tw_ready) begin
                n_tests++;
                if (idx >= TOTAL) begin
                    n_fail++;
                    $display("FAIL extra_word: got word %0d, required at most %0d", idx + 1,
                             TOTAL);
                end else begin
                    e_re = rom_re_f(exp_addr[idx]);
                    e_im = rom_im_f(exp_addr[idx]);
`ifdef TWID_CONJ_EN
                    if (inv_sel) e_im = (e_im == 16'sh8000) ? 16'sh7fff : -e_im;
`endif
                    if ({tw_re, tw_im, tw_stage, tw_bfly, tw_last} !==
                        {e_re, e_im, 4'(exp_s[idx]), (LOG2N - 1)'(exp_j[idx]),
                         (idx == TOTAL - 1)}) begin
                        n_fail++;
                        $display("FAIL word[%0d]: got re=%0d im=%0d s=%0d j=%0d last=%0b, required re=%0d im=%0d s=%0d j=%0d last=%0b",
                                 idx, tw_re, tw_im, tw_stage, tw_bfly, tw_last, e_re, e_im,
                                 exp_s[idx], exp_j[idx], (idx == TOTAL - 1));
                    end
                end
                last_hs = c;
                idx++;
            end

            prev_stall = tw_valid && !tw_ready;
            snap       = cur;
            if (!busy && idx >= TOTAL && done_cnt > 0) break;
        end

        start    = 1'b0;
        tw_ready = 1'b1;
        if (aborted) begin
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end else begin
            n_tests++;
            if (idx != TOTAL || done_cnt != 1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL sweep_end: got words=%0d done=%0d busy=%0b, required words=%0d done=1 busy=0",
                         idx, done_cnt, busy, TOTAL);
            end
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                #1;
                n_tests++;
                if (tw_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL post_sweep_idle: got valid=%0b done=%0b busy=%0b, required 0 0 0",
                             tw_valid, done, busy);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = ~start;
        end
        start = 1'b0;
        #1;
        n_tests++;
        if ({rom_addr, tw_valid, tw_re, tw_im, tw_stage, tw_bfly, tw_last, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%0d valid=%0b re=%0d im=%0d busy=%0b done=%0b, required all 0",
                     rom_addr, tw_valid, tw_re, tw_im, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || tw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%0b valid=%0b, required 0 0", busy, tw_valid);
        end
    endtask

    task automatic test_sweep();
        sweep(-1, 0, 1'b0, -1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        sweep(4, 3, 1'b0, -1, -1, 1'b0, 1'b0);
        for (int r = 0; r < 3; r++) sweep(-1, 0, 1'b1, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_midreset();
        sweep(-1, 0, 1'b0, 6, -1, 1'b0, 1'b0);
        sweep(-1, 0, 1'b0, -1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_start_busy();
        sweep(-1, 0, 1'b0, -1, 4, 1'b0, 1'b1);
    endtask

    task automatic test_conj();
        sweep(-1, 0, 1'b1, -1, -1, 1'b1, 1'b0);
        sweep(-1, 0, 1'b1, -1, -1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_backpressure();
        test_midreset();
        test_start_busy();
        test_conj();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
